// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin valid/ready arbiter sharing one registered ALU among NREQ requesters.
// Optional ALU_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins) instead of round-robin.
module alu_arbiter_alu (
   input  logic [4:0]  op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] result_o,
   output logic        flag_o
);
   always_comb begin
      result_o = '0;
      flag_o   = 1'b0;
      case (op_i)
         5'b00000: result_o = a_i + b_i;
         5'b01000: result_o = a_i - b_i;
         5'b00001: result_o = a_i << b_i[4:0];
         5'b00010: result_o = {31'b0, $signed(a_i) < $signed(b_i)};
         5'b00011: result_o = {31'b0, a_i < b_i};
         5'b00100: result_o = a_i ^ b_i;
         5'b00101: result_o = a_i >> b_i[4:0];
         5'b01101: result_o = $unsigned($signed(a_i) >>> b_i[4:0]);
         5'b00110: result_o = a_i | b_i;
         5'b00111: result_o = a_i & b_i;
         // branch compares report through Flag only
         5'b10000: flag_o = a_i == b_i;
         5'b10001: flag_o = a_i != b_i;
         5'b11100: flag_o = $signed(a_i) < $signed(b_i);
         5'b11101: flag_o = $signed(a_i) >= $signed(b_i);
         5'b11110: flag_o = a_i < b_i;
         5'b11111: flag_o = a_i >= b_i;
         default: ;
      endcase
   end
endmodule

module alu_arbiter #(
   parameter int NREQ = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [NREQ-1:0]   req_valid_i,
   output logic [NREQ-1:0]   req_ready_o,
   input  logic [NREQ*32-1:0] req_a_i,
   input  logic [NREQ*32-1:0] req_b_i,
   input  logic [NREQ*5-1:0] req_op_i,
   output logic [NREQ-1:0]   rsp_valid_o,
   input  logic [NREQ-1:0]   rsp_ready_i,
   output logic [31:0]       rsp_result_o,
   output logic              rsp_flag_o,
   output logic              busy_o
);
   localparam int IDX_W = $clog2(NREQ);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t state_q, state_d;
   logic [IDX_W-1:0] owner_q, owner_d, grant;
   logic [31:0] a_q, a_d, b_q, b_d, result_q, result_d, alu_result;
   logic [4:0] op_q, op_d;
   logic flag_q, flag_d, alu_flag, busy_q, busy_d, any_valid;
   logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
   assign any_valid = |req_valid_i;
`ifdef ALU_ARB_FIXED_PRIO_EN
   always_comb begin
      grant = '0;
      for (int i = NREQ - 1; i >= 0; i--)
         if (req_valid_i[IDX_W'(i)]) grant = IDX_W'(i);
   end
`else
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic found;
   // scan starts just past the last winner and wraps
   always_comb begin
      grant = '0;
      found = 1'b0;
      for (int i = 1; i <= NREQ; i++) begin
         if (!found && req_valid_i[IDX_W'((int'(rr_ptr_q) + i) % NREQ)]) begin
            found = 1'b1;
            grant = IDX_W'((int'(rr_ptr_q) + i) % NREQ);
         end
      end
   end
   assign rr_ptr_d = (state_q == IDLE && any_valid) ? grant : rr_ptr_q;
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) rr_ptr_q <= IDX_W'(NREQ - 1);
      else rr_ptr_q <= rr_ptr_d;
`endif
   assign req_ready_o = (state_q == IDLE && any_valid) ? (NREQ'(1) << grant) : '0;
   alu_arbiter_alu u_alu (.op_i(op_q), .a_i(a_q), .b_i(b_q), .result_o(alu_result), .flag_o(alu_flag));
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      result_d    = result_q;
      flag_d      = flag_q;
      rsp_valid_d = rsp_valid_q;
      busy_d      = busy_q;
      case (state_q)
         IDLE: if (any_valid) begin
            state_d = EXEC;
            owner_d = grant;
            a_d     = req_a_i[32*int'(grant) +: 32];
            b_d     = req_b_i[32*int'(grant) +: 32];
            op_d    = req_op_i[5*int'(grant) +: 5];
            busy_d  = 1'b1;
         end
         EXEC: begin
            state_d     = RESP;
            result_d    = alu_result;
            flag_d      = alu_flag;
            rsp_valid_d = NREQ'(1) << owner_q;
         end
         RESP: if (rsp_ready_i[owner_q]) begin
            state_d     = IDLE;
            rsp_valid_d = '0;
            busy_d      = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         owner_q     <= '0;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         result_q    <= '0;
         flag_q      <= 1'b0;
         rsp_valid_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         result_q    <= result_d;
         flag_q      <= flag_d;
         rsp_valid_q <= rsp_valid_d;
         busy_q      <= busy_d;
      end
   end
   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_result_o = result_q;
   assign rsp_flag_o   = flag_q;
   assign busy_o       = busy_q;
endmodule
